led_alarm_sequencer: RTL

- Downstream consumer of the 10-bit LED PIO output word; sits between the PIO register and the board LEDR pins.
- Normal mode: passes the software-written LED word through, registered.
- On an alarm trigger, takes over the LEDs:
  - runs a bouncing one-hot chaser for a bounded number of steps;
  - then flashes all LEDs;
  - then returns to pass-through.
- Software or a button can stop the alarm at any time.

---
 rtl/led_alarm_pkg.sv | 23 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_alarm_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/led_alarm_pkg.sv
// ----------------------------------------------------------------------------
// led_alarm_pkg
// Shared types and constants for the LED alarm sequencer and its tick
// generator: FSM state encoding, chaser direction values and the default
// timing constants for a 50 MHz system clock.
// ----------------------------------------------------------------------------
package led_alarm_pkg;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      CHASE = 2'd1,
      FLASH = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int DEF_WIDTH       = 10;
   localparam int DEF_TICK_DIV    = 5000000;  // 100 ms per step at 50 MHz
   localparam int DEF_ALARM_STEPS = 600;
   localparam int DEF_FLASH_STEPS = 16;

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
// Free-running prescaler counting 0..TICK_DIV-1. o_tick is high in the cycle
// the count sits at TICK_DIV-1; a synchronous clear restarts the count at 0
// so the first tick after a clear arrives TICK_DIV cycles later.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   i_clr    in   synchronous clear of the prescaler
//   o_tick   out  one-cycle animation step strobe
// ----------------------------------------------------------------------------
module led_tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int              CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_alarm_sequencer.sv
// ----------------------------------------------------------------------------
// led_alarm_sequencer
// Sits between the LED PIO register and the board LEDs. In PASS the software
// LED word is forwarded with one cycle of latency. A rising edge on
// alarm_trig starts a bouncing one-hot chaser for ALARM_STEPS animation
// ticks, then all LEDs flash for FLASH_STEPS ticks, then PASS resumes.
// alarm_stop aborts the alarm at the next edge and wins over tick and rise.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   led_word    in   LED value from the PIO register [WIDTH]
//   alarm_trig  in   level alarm request, rising edge acted on
//   alarm_stop  in   debounced stop request, level-sensitive
//   led_out     out  registered LED drive [WIDTH]
//   alarm_busy  out  registered, high in CHASE or FLASH
// ----------------------------------------------------------------------------
module led_alarm_sequencer
   import led_alarm_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int ALARM_STEPS = DEF_ALARM_STEPS,
   parameter int FLASH_STEPS = DEF_FLASH_STEPS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] led_word,
   input  logic             alarm_trig,
   input  logic             alarm_stop,
   output logic [WIDTH-1:0] led_out,
   output logic             alarm_busy
);

   localparam int POS_W   = $clog2(WIDTH);
   localparam int STEP_W  = $clog2(ALARM_STEPS);
   localparam int FLASH_W = $clog2(FLASH_STEPS + 1);

   localparam logic [POS_W-1:0]   POS_TOP    = POS_W'(WIDTH - 1);
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(ALARM_STEPS - 1);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_STEPS - 1);
   localparam logic [WIDTH-1:0]   ONE_HOT0   = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t             r_state, w_state_nxt;
   logic               r_trig_q;
   logic [POS_W-1:0]   r_pos, w_pos_nxt;
   logic               r_dir, w_dir_nxt;
   logic [STEP_W-1:0]  r_step, w_step_nxt;
   logic [FLASH_W-1:0] r_flash, w_flash_nxt;
   logic [WIDTH-1:0]   r_led, w_led_nxt;
   logic               r_busy;
   logic               w_rise;
   logic               w_tick;
   logic               w_state_chg;

   assign w_rise      = alarm_trig & ~r_trig_q;
   // Restarting the prescaler on every state change aligns the first step
   // of each phase to a full TICK_DIV period after entry.
   assign w_state_chg = (w_state_nxt != r_state);

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_state_chg),
      .o_tick  (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_dir_nxt   = r_dir;
      w_step_nxt  = r_step;
      w_flash_nxt = r_flash;
      w_led_nxt   = r_led;

      unique case (r_state)
         PASS: begin
            w_led_nxt = led_word;
            if (w_rise && !alarm_stop) begin
               w_state_nxt = CHASE;
               w_led_nxt   = ONE_HOT0;
               w_pos_nxt   = '0;
               w_dir_nxt   = DIR_UP;
               w_step_nxt  = '0;
            end
         end

         CHASE: begin
            if (alarm_stop) begin
               w_state_nxt = PASS;
               w_led_nxt   = led_word;
            end else if (w_tick) begin
               if (r_step == STEP_LAST) begin
                  w_state_nxt = FLASH;
                  w_led_nxt   = '1;
                  w_flash_nxt = '0;
               end else begin
                  w_step_nxt = r_step + STEP_W'(1);
                  // Reversal happens on the move away from an end LED, so
                  // each end is lit for exactly one step.
                  if (r_dir == DIR_UP) begin
                     if (r_pos == POS_TOP) begin
                        w_dir_nxt = DIR_DOWN;
                        w_pos_nxt = POS_TOP - POS_W'(1);
                     end else begin
                        w_pos_nxt = r_pos + POS_W'(1);
                     end
                  end else begin
                     if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                        w_pos_nxt = POS_W'(1);
                     end else begin
                        w_pos_nxt = r_pos - POS_W'(1);
                     end
                  end
                  w_led_nxt = ONE_HOT0 << w_pos_nxt;
               end
            end
         end

         FLASH: begin
            if (alarm_stop) begin
               w_state_nxt = PASS;
               w_led_nxt   = led_word;
            end else if (w_tick) begin
               if (r_flash == FLASH_LAST) begin
                  w_state_nxt = PASS;
                  w_led_nxt   = led_word;
               end else begin
                  w_led_nxt   = ~r_led;
                  w_flash_nxt = r_flash + FLASH_W'(1);
               end
            end
         end

         default: begin
            w_state_nxt = PASS;
            w_led_nxt   = led_word;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= PASS;
         r_trig_q <= 1'b0;
         r_pos    <= '0;
         r_dir    <= DIR_UP;
         r_step   <= '0;
         r_flash  <= '0;
         r_led    <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_trig_q <= alarm_trig;
         r_pos    <= w_pos_nxt;
         r_dir    <= w_dir_nxt;
         r_step   <= w_step_nxt;
         r_flash  <= w_flash_nxt;
         r_led    <= w_led_nxt;
         r_busy   <= (w_state_nxt != PASS);
      end
   end

   assign led_out    = r_led;
   assign alarm_busy = r_busy;

endmodule
